// File: rtl/pipe_muldiv.sv
// pipe_muldiv: multi-cycle multiply/divide unit with HI/LO registers,
// sitting beside EXE; busy feeds the ID-stage interlock.
// Ports: clock, resetn (async, active low); start/op/a/b launch an op;
//   flush aborts; mthi/mtlo/wdata write HI/LO when idle;
//   busy, done, div_zero status; hi/lo registers.
// Optional: define PIPE_MULDIV_MADD_EN to add the acc input (MADD/MADDU).
module pipe_muldiv #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
`ifdef PIPE_MULDIV_MADD_EN
    input  logic             acc,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + MUL_LAT + 1);
    localparam logic [CW-1:0] DIV_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MUL_CNT =
        CW'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    // Multiply: r_quo/r_div hold the operands.
    // Divide: r_rem/r_quo form the shifting remainder/quotient pair.
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_sgn;
    logic             r_zero;
    logic             r_neg_q;
    logic             r_neg_r;
`ifdef PIPE_MULDIV_MADD_EN
    logic             r_acc;
`endif

    logic               w_accept;
    logic               w_b_zero;
    logic               w_sdiv;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;

    assign w_accept = (r_state == S_IDLE) && start && !flush;
    assign w_b_zero = (b == '0);
    assign w_sdiv   = (op == 2'b10);

    assign w_a_mag = (w_sdiv && a[WIDTH-1]) ? -a : a;
    assign w_b_mag = (w_sdiv && b[WIDTH-1]) ? -b : b;

    assign w_ext_a = {{WIDTH{r_sgn & r_quo[WIDTH-1]}}, r_quo};
    assign w_ext_b = {{WIDTH{r_sgn & r_div[WIDTH-1]}}, r_div};
    assign w_prod  = w_ext_a * w_ext_b;

    // Restoring step: a set top bit of w_diff means the trial
    // subtraction went negative and the remainder is kept.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    assign w_q = r_neg_q ? -r_quo : r_quo;
    assign w_r = r_neg_r ? -r_rem : r_rem;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[1]) begin
                            w_next = (MUL_LAT == 1) ? S_FIN : S_MUL;
                        end else begin
                            w_next = w_b_zero ? S_FIN : S_DIV;
                        end
                    end
                end
                S_MUL:   if (r_cnt == '0) w_next = S_FIN;
                S_DIV:   if (r_cnt == '0) w_next = S_FIN;
                S_FIN:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sgn    <= 1'b0;
            r_zero   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
`ifdef PIPE_MULDIV_MADD_EN
            r_acc    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            r_busy <= (w_next != S_IDLE);
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= op[1] ? DIV_CNT : MUL_CNT;
                        r_is_div <= op[1];
                        r_sgn    <= ~op[0];
                        r_zero   <= op[1] && w_b_zero;
                        r_neg_q  <= w_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r  <= w_sdiv && a[WIDTH-1];
`ifdef PIPE_MULDIV_MADD_EN
                        r_acc    <= acc && !op[1];
`endif
                        if (!op[1]) begin
                            r_rem <= '0;
                            r_quo <= a;
                            r_div <= b;
                        end else if (w_b_zero) begin
                            // Dividend parked here; it becomes hi.
                            r_rem <= a;
                            r_quo <= '0;
                            r_div <= '0;
                        end else begin
                            r_rem <= '0;
                            r_quo <= w_a_mag;
                            r_div <= w_b_mag;
                        end
                    end else if (!start) begin
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                S_MUL: begin
                    r_cnt <= r_cnt - CW'(1);
                end
                S_DIV: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (!w_diff[WIDTH]) begin
                        r_rem <= w_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIN: begin
                    if (!flush) begin
                        r_done <= 1'b1;
                        r_dz   <= r_zero;
                        if (r_zero) begin
                            r_lo <= '1;
                            r_hi <= r_rem;
                        end else if (r_is_div) begin
                            r_lo <= w_q;
                            r_hi <= w_r;
`ifdef PIPE_MULDIV_MADD_EN
                        end else if (r_acc) begin
                            {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
`endif
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_pipe_muldiv.sv
// tb_pipe_muldiv: directed bench for pipe_muldiv with a cycle-level
// reference model compared against the outputs every cycle.
module tb_pipe_muldiv;

    localparam int W  = 32;
    localparam int ML = 4;
`ifdef PIPE_MULDIV_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    logic         clock  = 1'b0;
    logic         resetn = 1'b0;
    logic         start  = 1'b0;
    logic [1:0]   op     = 2'b00;
    logic [W-1:0] a      = '0;
    logic [W-1:0] b      = '0;
    logic         flush  = 1'b0;
    logic         mthi   = 1'b0;
    logic         mtlo   = 1'b0;
    logic [W-1:0] wdata  = '0;
    logic         acc    = 1'b0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    always #5 clock = ~clock;

    pipe_muldiv #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .wdata    (wdata),
`ifdef PIPE_MULDIV_MADD_EN
        .acc      (acc),
`endif
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_dz   = 0;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: an op is a pending result plus a cycle count.
    logic         m_busy, m_done, m_dz;
    logic [W-1:0] m_hi, m_lo;
    logic [W-1:0] p_hi, p_lo;
    logic [2*W-1:0] p_prod;
    logic         p_dz, p_mul, p_acc;
    int           m_left;
    longint       sa, sb;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_busy = 0; m_done = 0; m_dz = 0;
            m_hi = '0; m_lo = '0; m_left = 0;
            p_hi = '0; p_lo = '0; p_prod = '0;
            p_dz = 0; p_mul = 0; p_acc = 0;
        end else begin
            m_done = 0;
            m_dz   = 0;
            if (m_busy) begin
                if (flush) begin
                    m_busy = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0;
                        m_done = 1;
                        m_dz   = p_dz;
                        if (p_mul)
                            {m_hi, m_lo} = (p_acc ? {m_hi, m_lo} : '0)
                                           + p_prod;
                        else begin
                            m_hi = p_hi;
                            m_lo = p_lo;
                        end
                    end
                end
            end else if (start) begin
                if (!flush) begin
                    m_busy = 1;
                    p_dz   = 0;
                    sa     = $signed(a);
                    sb     = $signed(b);
                    if (!op[1]) begin
                        p_mul  = 1;
                        p_acc  = acc & MADD;
                        m_left = ML;
                        if (op[0]) p_prod = {32'b0, a} * {32'b0, b};
                        else       p_prod = 64'(sa * sb);
                    end else begin
                        p_mul = 0;
                        p_acc = 0;
                        if (b == '0) begin
                            m_left = 1;
                            p_dz   = 1;
                            p_lo   = '1;
                            p_hi   = a;
                        end else begin
                            m_left = W + 1;
                            if (op[0]) begin
                                p_lo = a / b;
                                p_hi = a % b;
                            end else begin
                                p_lo = W'(sa / sb);
                                p_hi = W'(sa % sb);
                            end
                        end
                    end
                end
            end else begin
                if (mthi) m_hi = wdata;
                if (mtlo) m_lo = wdata;
            end
        end
    end

    always @(negedge clock) begin
        chk("busy", W'(busy), W'(m_busy));
        chk("done", W'(done), W'(m_done));
        chk("div_zero", W'(div_zero), W'(m_dz));
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (done) n_done++;
        if (div_zero) n_dz++;
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic ac);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        acc   = ac;
        @(negedge clock);
        start = 1'b0;
        acc   = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("busy_timeout", W'(busy), '0);
    endtask

    int n, d0, z0;

    initial begin
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_busy", W'(busy), '0);
        resetn = 1'b1;

        // mult -3 * 5
        d0 = n_done;
        issue(2'b00, -3, 5, 1'b0);
        wait_idle(n);
        chk("mult_busy_cycles", n, 4);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        @(negedge clock); #2;
        chk("mult_done_count", n_done - d0, 1);

        // multu with an ignored second start
        d0 = n_done;
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        start = 1'b1; op = 2'b00; a = 2; b = 3;
        @(negedge clock);
        start = 1'b0;
        wait_idle(n);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        repeat (3) @(negedge clock);
        #2;
        chk("multu_done_count", n_done - d0, 1);
        chk("multu_hi_kept", hi, 32'hFFFFFFFE);

        // signed divide, then unsigned divide
        issue(2'b10, -7, 2, 1'b0);
        wait_idle(n);
        chk("div_busy_cycles", n, 33);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        issue(2'b11, 100, 7, 1'b0);
        wait_idle(n);
        chk("divu_lo", lo, 32'h0000000E);
        chk("divu_hi", hi, 32'h00000002);

        // divide by zero
        z0 = n_dz;
        issue(2'b11, 32'h64, 0, 1'b0);
        wait_idle(n);
        chk("dz_busy_cycles", n, 1);
        chk("dz_flag", W'(div_zero), 1);
        chk("dz_done", W'(done), 1);
        chk("dz_lo", lo, 32'hFFFFFFFF);
        chk("dz_hi", hi, 32'h00000064);
        @(negedge clock); #2;
        chk("dz_count", n_dz - z0, 1);

        // mthi/mtlo, then a flushed divide
        @(negedge clock);
        mthi = 1'b1; wdata = 32'h12345678;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h9ABCDEF0;
        @(negedge clock);
        mtlo = 1'b0;
        chk("mthi_val", hi, 32'h12345678);
        chk("mtlo_val", lo, 32'h9ABCDEF0);
        d0 = n_done;
        issue(2'b10, 1000, 3, 1'b0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_busy", W'(busy), '0);
        repeat (40) @(negedge clock);
        chk("flush_hi", hi, 32'h12345678);
        chk("flush_lo", lo, 32'h9ABCDEF0);
        #2;
        chk("flush_no_done", n_done - d0, 0);

        // most-negative / -1
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_idle(n);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h00000000);

        // start beats mthi
        @(negedge clock);
        start = 1'b1; op = 2'b01; a = 2; b = 3;
        mthi = 1'b1; wdata = 32'hDEADBEEF;
        @(negedge clock);
        start = 1'b0; mthi = 1'b0;
        wait_idle(n);
        chk("startwin_hi", hi, 32'h0);
        chk("startwin_lo", lo, 32'h6);

        // flush cancels a start in idle
        @(negedge clock);
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 5; b = 5;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        chk("flushstart_busy", W'(busy), '0);
        repeat (6) @(negedge clock);
        chk("flushstart_lo", lo, 32'h6);

        // asynchronous reset mid-multiply
        issue(2'b00, 7, 9, 1'b0);
        @(negedge clock);
        #3 resetn = 1'b0;
        #1;
        chk("arst_busy", W'(busy), '0);
        chk("arst_lo", lo, '0);
        chk("arst_hi", hi, '0);
        @(negedge clock);
        resetn = 1'b1;
        issue(2'b00, 6, 7, 1'b0);
        wait_idle(n);
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_hi", hi, 32'd0);

`ifdef PIPE_MULDIV_MADD_EN
        @(negedge clock);
        mthi = 1'b1; wdata = 32'd0;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'd10;
        @(negedge clock);
        mtlo = 1'b0;
        issue(2'b00, 3, 4, 1'b1);
        wait_idle(n);
        chk("madd_lo", lo, 32'd22);
        chk("madd_hi", hi, 32'd0);
`endif

        repeat (2) @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_muldiv.md
Name: pipe_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit with HI/LO registers, attached beside the EXE stage of the 5-stage pipeline. It gives the pipeline MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO support, which the current single-cycle ALU datapath lacks. The unit drives busy into the ID-stage interlock, and the interlock stalls the pipeline through wpcir. A flush input aborts an in-flight operation on branch or exception squash.

Parameters:
WIDTH, 32, operand and HI/LO width; must be ≥4.
MUL_LAT, 4, multiply latency in cycles; must be ≥1.

Ports:
clock  input  1  pipeline clock; all state changes on the rising edge.
resetn  input  1  asynchronous active-low reset.
start  input  1  launch the operation selected by op; sampled only in IDLE.
op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
a  input  WIDTH  multiplicand / dividend.
b  input  WIDTH  multiplier / divisor.
flush  input  1  abort the in-flight operation.
mthi  input  1  write wdata to hi; honoured only in IDLE.
mtlo  input  1  write wdata to lo; honoured only in IDLE.
wdata  input  WIDTH  data for mthi/mtlo.
busy  output  1  operation in progress; feeds the stall logic.
done  output  1  one-cycle pulse when hi/lo are updated by an operation.
div_zero  output  1  one-cycle pulse together with done when the divisor is 0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, resetn=0):
  - hi=0, lo=0, busy=0, done=0, div_zero=0.
  - State=IDLE; internal counters and shift registers cleared.
  - Reset during an operation discards it immediately.
- States and transitions:
  - IDLE --start, op[1]=0--> MUL.
  - IDLE --start, op[1]=1, b≠0--> DIV.
  - IDLE --start, op[1]=1, b=0--> FIN.
  - MUL --count done--> FIN.
  - DIV --WIDTH iterations done--> FIN.
  - FIN --> IDLE.
  - Any state --flush--> IDLE.
- busy is registered: it rises on the edge that accepts start and falls on the edge entering IDLE.
- done and div_zero are registered: both assert in the cycle after FIN, i.e. when hi/lo first show the new value.
- start while busy=1 is ignored. The issuer must hold the instruction stalled until busy=0.
- Multiply:
  - Operands are captured at start. The 2*WIDTH product is formed by sign-extending (op=00) or zero-extending (op=01) both operands.
  - The product travels through a (MUL_LAT-1)-deep register chain or down-counter.
  - {hi,lo} is written on the edge exactly MUL_LAT cycles after the start edge. busy is high for MUL_LAT cycles.
- Divide:
  - Restoring algorithm, one quotient bit per cycle.
  - Signed (op=10): divide magnitudes, then sign-fix in FIN. Quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - lo=quotient, hi=remainder, written WIDTH+1 cycles after the start edge (WIDTH iterations plus FIN). busy is high for WIDTH+1 cycles.
  - Most-negative / -1 (signed): lo=most-negative, hi=0, no overflow flag.
- Divide by zero: FIN on the next edge, then lo=all-ones, hi=a, done=1, div_zero=1. Total latency 2 cycles.
- mthi/mtlo:
  - Take effect on the next edge when in IDLE and start=0.
  - If start and mthi/mtlo are both asserted, start wins and the write is dropped.
  - mthi/mtlo while busy are ignored.
- flush:
  - Any state returns to IDLE next edge, busy=0, hi/lo unchanged, no done pulse.
  - flush in the same cycle as start in IDLE cancels the start.
  - flush in the FIN cycle suppresses the hi/lo write.
- hi/lo change only on operation completion, mthi/mtlo, or reset.

Optional Feature:
PIPE_MULDIV_MADD_EN
- Defined:
  - Adds input port acc (1 bit), sampled with start.
  - For multiply with acc=1, {hi,lo} ← {hi,lo} + product, computed as 2*WIDTH wrap-around addition (MADD/MADDU).
  - {hi,lo} used is the value at completion time; latency unchanged.
  - acc is ignored for divide.
- Undefined: no acc port; multiply always overwrites {hi,lo}.

Test Plan:
1. WIDTH=32, MUL_LAT=4. mult a=-3, b=5 → busy high 4 cycles; hi=FFFFFFFF, lo=FFFFFFF1; done pulses once.
2. multu a=b=FFFFFFFF → hi=FFFFFFFE, lo=00000001 after 4 cycles. A second start issued mid-operation is ignored; result unchanged.
3. div a=-7, b=2 → lo=FFFFFFFD, hi=FFFFFFFF after 33 cycles. Then divu a=100, b=7 → lo=0000000E, hi=00000002.
4. divu a=00000064, b=0 → 2 cycles later: div_zero=1, done=1, lo=FFFFFFFF, hi=00000064.
5. mthi wdata=12345678, then mtlo wdata=9ABCDEF0, then div started with flush on its 10th busy cycle → busy=0 next cycle; hi=12345678 and lo=9ABCDEF0 retained; no done pulse.
6. resetn pulsed low mid-multiply, asynchronously between edges → hi=lo=0 and busy=0 immediately; next start completes normally. With PIPE_MULDIV_MADD_EN: hi=0, lo=10, madd 3*4 → lo=22.
